sha256_msg_sched: RTL and testbench
===================================

# sha256_msg_sched

Message-schedule expander for the SHA-256 datapath. It accepts one 512-bit message block over a valid/ready handshake and computes the 64-word schedule W[0..63] iteratively, one word per cycle. It then presents the full array to the downstream compression-round counter. It sits directly upstream of that counter, which consumes the complete W array in parallel.

## Interface
- ROUNDS, 64, number of schedule words produced; legal range 17..64; entries ROUNDS..63 of w_out are driven 0.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- blk_valid  in  1  blk_data holds a block to be accepted.
- blk_ready  out  1  block can be accepted this cycle.
- blk_data  in  512  message block; word M[i] = blk_data[511-32*i -: 32], big-endian word order.
- w_valid  out  1  w_out holds a complete schedule.
- w_ready  in  1  consumer takes w_out this cycle.
- w_out  out  [0:63][31:0]  schedule array; element i = W[i].
- busy  out  1  high in EXPAND and DONE.

## Operation
- States: IDLE, EXPAND, DONE.
- Internal state: word array w[0:63], 6-bit index cnt.
- Transfer in: blk_valid && blk_ready at a clock edge. Transfer out: w_valid && w_ready at a clock edge.
- IDLE:
  - blk_ready=1, w_valid=0.
  - On a transfer in: w[0..15] <= M[0..15], w[16..63] <= 0, cnt <= 16, then go to EXPAND.
- EXPAND:
  - blk_ready=0, w_valid=0.
  - Each edge: w[cnt] <= σ1(w[cnt-2]) + w[cnt-7] + σ0(w[cnt-15]) + w[cnt-16], sum mod 2^32; cnt <= cnt+1.
  - The edge that writes w[ROUNDS-1] moves the state to DONE.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x). σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x). All operations are 32-bit and unsigned; carries out of bit 31 are discarded.
- DONE:
  - w_valid=1, and w_out is held stable until a transfer out.
  - blk_ready = w_ready.
  - Transfer out with no transfer in: go to IDLE.
  - Transfer out and transfer in on the same edge: load the new block exactly as from IDLE, go to EXPAND. w_valid drops on the next cycle.
- w_out is driven directly from the w registers; there is no combinational path from blk_data to w_out.
- The cnt source indices cnt-2, cnt-7, cnt-15 and cnt-16 never wrap, because cnt ≥ 16 throughout EXPAND.

## Timing
- Reset values: state=IDLE, cnt=0, all w=0, w_valid=0, busy=0. blk_ready=0 while reset is high and 1 from the first cycle after reset deasserts.
- A blk_valid that is high during reset is ignored.
- Latency: acceptance edge T0. Words W[16..ROUNDS-1] are written on edges T1..T(ROUNDS-16). w_valid rises after edge T(ROUNDS-16); for ROUNDS=64 this is T48.
- Throughput: one block every ROUNDS-15 cycles when w_ready is held high (49 cycles for ROUNDS=64).
- Backpressure: w_ready low in DONE holds the state, w_out and w_valid indefinitely; blk_ready stays 0.
- Reset mid-EXPAND or mid-DONE: the block is discarded, all w are cleared, no w_valid pulse is produced, and the next state is IDLE.
- blk_valid in EXPAND is ignored. blk_data must be held stable by the producer until the block is accepted.

## Configuration
- SHA256_SCHED_BSWAP_EN defined: each input word M[i] is byte-reversed before loading (bytes 0↔3 and 1↔2), for little-endian producers.
- SHA256_SCHED_BSWAP_EN undefined: words are loaded exactly as given.
- The macro affects only the load path; expansion and output are identical in both builds.

## Test plan
- Reset then "abc" padded block (M0=0x61626380, M15=0x00000018, other words 0), w_ready=1:
  - w_valid rises 48 edges after acceptance.
  - W[16]=0x61626380, W[17]=0x000F0000, W[63]=0x12B1EDEB.
  - Compare all 64 words against a reference model.
- Same block with w_ready=0 for 20 cycles in DONE: w_out stable, blk_ready=0, w_valid=1 throughout. Raise w_ready: one transfer, then IDLE.
- Back-to-back blocks: second block offered with w_ready=1 in DONE.
  - Accepted on the same edge as the output transfer; no idle cycle.
  - Second schedule correct 48 edges later.
- All-ones block (every M[i]=0xFFFFFFFF): verify modulo-2^32 wraparound against the model for all W.
- Reset asserted at EXPAND cnt=30: next cycle state IDLE, all w_out=0, w_valid never asserts. A fresh block afterwards produces the correct schedule.
- Build with SHA256_SCHED_BSWAP_EN and feed M0=0x80636261, M15=0x18000000: output identical to the "abc" scenario.

Source files
------------

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched -- SHA-256 message-schedule expander.
// Accepts one 512-bit block over a valid/ready handshake and expands it to
// W[0..ROUNDS-1], one word per clock. The finished array is then held on
// w_out until the consumer takes it.
// Build option: define SHA256_SCHED_BSWAP_EN to byte-reverse every input word
// at load time, for little-endian producers.
module sha256_msg_sched #(
  parameter int ROUNDS = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                blk_valid,
  output logic                blk_ready,
  input  logic [511:0]        blk_data,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [0:63][31:0]   w_out,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] w [0:63];
  logic [5:0]  cnt;
  logic [31:0] w_new;
  logic        xfer_in;
  logic        xfer_out;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Extract message word M[i] (big-endian word order), optionally byte-reversed.
  function automatic logic [31:0] load_word(input logic [511:0] blk, input int i);
    logic [31:0] m;
    m = blk[511-32*i -: 32];
`ifdef SHA256_SCHED_BSWAP_EN
    return {m[7:0], m[15:8], m[23:16], m[31:24]};
`else
    return m;
`endif
  endfunction

  assign xfer_in  = blk_valid && blk_ready;
  assign xfer_out = w_valid && w_ready;

  // New schedule word for slot cnt; cnt >= 16 in EXPAND so no index wraps.
  assign w_new = sig1(w[cnt - 6'd2]) + w[cnt - 6'd7]
               + sig0(w[cnt - 6'd15]) + w[cnt - 6'd16];

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and a latch cannot be inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer_in) state_nxt = EXPAND;
      EXPAND:  if (cnt == LAST_IDX) state_nxt = DONE;
      DONE:    if (xfer_out) state_nxt = xfer_in ? EXPAND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs; blk_ready is held low while reset is high.
  always_comb begin
    blk_ready = 1'b0;
    w_valid   = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:   blk_ready = !reset;
      EXPAND: busy      = 1'b1;
      DONE: begin
        w_valid   = 1'b1;
        busy      = 1'b1;
        blk_ready = w_ready && !reset;
      end
      default: ;
    endcase
  end

  // Word array and index: load on acceptance, one word per cycle in EXPAND.
  // NOTE: the word array is reset explicitly because a reset must leave w_out
  // all-zero; this rules out mapping it onto a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      for (int i = 0; i < 64; i++) w[i] <= '0;
    end else if (xfer_in) begin
      cnt <= 6'd16;
      for (int i = 0; i < 64; i++) w[i] <= (i < 16) ? load_word(blk_data, i) : '0;
    end else if (state == EXPAND) begin
      w[cnt] <= w_new;
      cnt    <= cnt + 6'd1;
    end
  end

  // Output array straight from the registers; slots past ROUNDS read as zero.
  always_comb begin
    for (int i = 0; i < 64; i++) w_out[i] = (i < ROUNDS) ? w[i] : '0;
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched -- self-checking bench for sha256_msg_sched.
// Table of blocks (known-answer words plus a reference model), then
// hand-written back-to-back and reset-during-expansion sequences.
// Honours SHA256_SCHED_BSWAP_EN the same way the design does.
module tb_sha256_msg_sched;

  localparam int ROUNDS = 64;
  localparam int LAT    = ROUNDS - 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              blk_valid;
  logic              blk_ready;
  logic [511:0]      blk_data;
  logic              w_valid;
  logic              w_ready;
  logic [0:63][31:0] w_out;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_w [0:63];

  typedef struct {
    string        name;
    logic [511:0] blk;
    int           hold;     // cycles w_ready is held low in DONE
    int           kat_idx;  // -1: no known-answer word
    logic [31:0]  kat_val;
  } vec_t;

  vec_t vecs [7];

  sha256_msg_sched #(.ROUNDS(ROUNDS)) dut (
    .clk      (clk),
    .reset    (reset),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .blk_data (blk_data),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_out    (w_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule from the textbook recurrence, sums taken mod 2^32.
  task automatic compute_model(input logic [511:0] blk);
    logic [31:0] m;
    longint unsigned s;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        m = blk[511-32*t -: 32];
`ifdef SHA256_SCHED_BSWAP_EN
        m = {m[7:0], m[15:8], m[23:16], m[31:24]};
`endif
        exp_w[t] = m;
      end else if (t < ROUNDS) begin
        s = longint'(rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
          + longint'(exp_w[t-7])
          + longint'(rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
          + longint'(exp_w[t-16]);
        exp_w[t] = 32'(s % 64'h1_0000_0000);
      end else begin
        exp_w[t] = '0;
      end
    end
  endtask

  task automatic check_words(input string tag);
    for (int i = 0; i < 64; i++) check($sformatf("%s w[%0d]", tag, i), w_out[i], exp_w[i]);
  endtask

  // Offer a block from IDLE; returns at the negedge after the acceptance edge.
  task automatic send_block(input logic [511:0] blk);
    int k = 0;
    @(negedge clk);
    blk_data  = blk;
    blk_valid = 1'b1;
    #1;
    while (!blk_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("accept_ready", blk_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    blk_valid = 1'b0;
    check("expand_busy", busy, 1'b1);
    check("expand_no_valid", w_valid, 1'b0);
  endtask

  // Wait (bounded) for w_valid and check the acceptance-to-valid edge count.
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!w_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, LAT);
  endtask

  logic [511:0] abc_blk;
  logic [511:0] rnd_blk;

  initial begin
    int highs;

`ifdef SHA256_SCHED_BSWAP_EN
    abc_blk = {32'h80636261, 448'h0, 32'h18000000};
`else
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
`endif

    vecs[0] = '{"abc_hold20", abc_blk, 20, 16, 32'h61626380};
    vecs[1] = '{"abc_w17",    abc_blk, 0,  17, 32'h000F0000};
    vecs[2] = '{"abc_w63",    abc_blk, 2,  63, 32'h12B1EDEB};
    vecs[3] = '{"all_ones",   {512{1'b1}}, 1, -1, 32'h0};
    vecs[4] = '{"all_zero",   512'h0,  1,  63, 32'h0};
    for (int v = 5; v < 7; v++) begin
      for (int j = 0; j < 16; j++) rnd_blk[511-32*j -: 32] = $urandom();
      vecs[v] = '{$sformatf("random%0d", v), rnd_blk, 3, -1, 32'h0};
    end

    // Reset with blk_valid high: the block must be ignored.
    reset     = 1'b1;
    blk_valid = 1'b1;
    blk_data  = abc_blk;
    w_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst blk_ready", blk_ready, 1'b0);
    check("rst w_valid", w_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    for (int i = 0; i < 64; i++) check($sformatf("rst w[%0d]", i), w_out[i], 32'h0);
    reset     = 1'b0;
    blk_valid = 1'b0;
    @(negedge clk);
    check("post_rst blk_ready", blk_ready, 1'b1);
    check("post_rst busy", busy, 1'b0);

    // Table-driven blocks with backpressure in DONE.
    for (int v = 0; v < 7; v++) begin
      compute_model(vecs[v].blk);
      send_block(vecs[v].blk);
      wait_valid(vecs[v].name);
      check_words(vecs[v].name);
      if (vecs[v].kat_idx >= 0)
        check({vecs[v].name, " kat"}, w_out[vecs[v].kat_idx], vecs[v].kat_val);
      for (int c = 0; c < vecs[v].hold; c++) begin
        @(negedge clk);
        check({vecs[v].name, " hold w_valid"}, w_valid, 1'b1);
        check({vecs[v].name, " hold blk_ready"}, blk_ready, 1'b0);
        check({vecs[v].name, " hold busy"}, busy, 1'b1);
        check_words({vecs[v].name, " hold"});
      end
      w_ready = 1'b1;
      #1;
      check({vecs[v].name, " done blk_ready"}, blk_ready, 1'b1);
      @(negedge clk);
      w_ready = 1'b0;
      check({vecs[v].name, " after w_valid"}, w_valid, 1'b0);
      check({vecs[v].name, " after busy"}, busy, 1'b0);
    end

    // Back-to-back: second block accepted on the output-transfer edge.
    compute_model(vecs[5].blk);
    send_block(vecs[5].blk);
    wait_valid("b2b first");
    check_words("b2b first");
    blk_data  = vecs[6].blk;
    blk_valid = 1'b1;
    w_ready   = 1'b1;
    #1;
    check("b2b blk_ready", blk_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    blk_valid = 1'b0;
    check("b2b w_valid drop", w_valid, 1'b0);
    check("b2b busy", busy, 1'b1);
    compute_model(vecs[6].blk);
    wait_valid("b2b second");
    check_words("b2b second");
    @(negedge clk);
    w_ready = 1'b0;
    check("b2b idle w_valid", w_valid, 1'b0);
    check("b2b idle busy", busy, 1'b0);

    // Reset while expanding at cnt=30 (14 edges after acceptance).
    send_block(vecs[3].blk);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst busy", busy, 1'b0);
    check("midrst w_valid", w_valid, 1'b0);
    check("midrst blk_ready", blk_ready, 1'b0);
    for (int i = 0; i < 64; i++) check($sformatf("midrst w[%0d]", i), w_out[i], 32'h0);
    reset = 1'b0;
    highs = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (w_valid) highs++;
    end
    check("midrst no w_valid", highs, 0);
    check("midrst idle busy", busy, 1'b0);
    compute_model(abc_blk);
    send_block(abc_blk);
    wait_valid("post_midrst");
    check_words("post_midrst");
    check("post_midrst w63", w_out[63], 32'h12B1EDEB);
    w_ready = 1'b1;
    @(negedge clk);
    w_ready = 1'b0;
    check("post_midrst idle", w_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
